// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter
// Shares one 8-bit 2:1 byte mux between two requesters (A and B) and
// registers the selected byte into a single valid/ready output channel.
//
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset
//   req_a/data_a/ack_a   - requester A: level request, byte, capture pulse
//   req_b/data_b/ack_b   - requester B: level request, byte, capture pulse
//   sel                  - shared mux select (0 = A, 1 = B)
//   out_data/out_valid   - registered output byte and its valid flag
//   out_ready            - consumer accepts out_data when out_valid is high
//   busy                 - high whenever the arbiter is not idle
//   cnt_a/cnt_b          - saturating completed-transfer counters
//
// Parameters:
//   CNT_W     - counter width
//   FIXED_PRI - 0: round-robin on contention, 1: A always wins contention
module mux_share_arbiter #(
    parameter int CNT_W     = 8,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [7:0]       data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [7:0]       data_b,
    output logic             ack_b,
    output logic             sel,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    state_t           state_r,      state_s;
    logic             sel_r,        sel_s;
    logic             last_grant_r, last_grant_s;
    logic [7:0]       out_data_r,   out_data_s;
    logic             out_valid_r,  out_valid_s;
    logic             ack_a_r,      ack_a_s;
    logic             ack_b_r,      ack_b_s;
    logic             busy_r,       busy_s;
    logic [CNT_W-1:0] cnt_a_r,      cnt_a_s;
    logic [CNT_W-1:0] cnt_b_r,      cnt_b_s;

    // Saturating increment: an all-ones counter stays put instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s      = state_r;
        sel_s        = sel_r;
        last_grant_s = last_grant_r;
        out_data_s   = out_data_r;
        out_valid_s  = out_valid_r;
        ack_a_s      = 1'b0;
        ack_b_s      = 1'b0;
        cnt_a_s      = cnt_a_r;
        cnt_b_s      = cnt_b_r;

        case (state_r)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    // last_grant resets to B so A wins the first contest.
                    sel_s   = FIXED_PRI ? 1'b0 : ~last_grant_r;
                    state_s = ST_LOAD;
                end else if (req_a) begin
                    sel_s   = 1'b0;
                    state_s = ST_LOAD;
                end else if (req_b) begin
                    sel_s   = 1'b1;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                out_data_s  = sel_r ? data_b : data_a;
                out_valid_s = 1'b1;
                ack_a_s     = ~sel_r;
                ack_b_s     = sel_r;
                state_s     = ST_SEND;
            end
            ST_SEND: begin
                if (out_valid_r && out_ready) begin
                    out_valid_s  = 1'b0;
                    last_grant_s = sel_r;
                    if (sel_r) begin
                        cnt_b_s = sat_inc(cnt_b_r);
                    end else begin
                        cnt_a_s = sat_inc(cnt_a_r);
                    end
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SEND;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase

        // busy is registered, so it follows the state being entered.
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset drops any in-flight byte without ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            sel_r        <= 1'b0;
            last_grant_r <= 1'b1;
            out_data_r   <= 8'h00;
            out_valid_r  <= 1'b0;
            ack_a_r      <= 1'b0;
            ack_b_r      <= 1'b0;
            busy_r       <= 1'b0;
            cnt_a_r      <= {CNT_W{1'b0}};
            cnt_b_r      <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_s;
            sel_r        <= sel_s;
            last_grant_r <= last_grant_s;
            out_data_r   <= out_data_s;
            out_valid_r  <= out_valid_s;
            ack_a_r      <= ack_a_s;
            ack_b_r      <= ack_b_s;
            busy_r       <= busy_s;
            cnt_a_r      <= cnt_a_s;
            cnt_b_r      <= cnt_b_s;
        end
    end

    assign sel       = sel_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign ack_a     = ack_a_r;
    assign ack_b     = ack_b_r;
    assign busy      = busy_r;
    assign cnt_a     = cnt_a_r;
    assign cnt_b     = cnt_b_r;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed testbench for mux_share_arbiter.
// dut0: round-robin, 8-bit counters (reset, single, mid-SEND reset, RR, backpressure)
// dut1: fixed priority (A wins contention)
// dut2: round-robin with 2-bit counters (saturation)
module tb_mux_share_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic       req_a0, req_b0, ack_a0, ack_b0, sel0, out_valid0, out_ready0, busy0;
    logic [7:0] data_a0, data_b0, out_data0;
    logic [7:0] cnt_a0, cnt_b0;

    logic       req_a1, req_b1, ack_a1, ack_b1, sel1, out_valid1, out_ready1, busy1;
    logic [7:0] data_a1, data_b1, out_data1;
    logic [7:0] cnt_a1, cnt_b1;

    logic       req_a2, req_b2, ack_a2, ack_b2, sel2, out_valid2, out_ready2, busy2;
    logic [7:0] data_a2, data_b2, out_data2;
    logic [1:0] cnt_a2, cnt_b2;

    int n_checks = 0;
    int n_fail   = 0;

    int hs0_cnt   = 0;
    int ackb0_cnt = 0;
    int ackb1_cnt = 0;
    int hs_base;
    int ackb_base;
    bit found;

    logic [7:0] rr_exp [4] = '{8'h11, 8'h22, 8'h11, 8'h22};

    always #5 clk = ~clk;

    mux_share_arbiter #(.CNT_W(8), .FIXED_PRI(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a0), .data_a(data_a0), .ack_a(ack_a0),
        .req_b(req_b0), .data_b(data_b0), .ack_b(ack_b0),
        .sel(sel0), .out_data(out_data0), .out_valid(out_valid0),
        .out_ready(out_ready0), .busy(busy0), .cnt_a(cnt_a0), .cnt_b(cnt_b0)
    );

    mux_share_arbiter #(.CNT_W(8), .FIXED_PRI(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a1), .data_a(data_a1), .ack_a(ack_a1),
        .req_b(req_b1), .data_b(data_b1), .ack_b(ack_b1),
        .sel(sel1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .busy(busy1), .cnt_a(cnt_a1), .cnt_b(cnt_b1)
    );

    mux_share_arbiter #(.CNT_W(2), .FIXED_PRI(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a2), .data_a(data_a2), .ack_a(ack_a2),
        .req_b(req_b2), .data_b(data_b2), .ack_b(ack_b2),
        .sel(sel2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready2), .busy(busy2), .cnt_a(cnt_a2), .cnt_b(cnt_b2)
    );

    // Event counters sampled with pre-edge values at each rising edge.
    always @(posedge clk) begin
        if (out_valid0 && out_ready0) hs0_cnt <= hs0_cnt + 1;
        if (ack_b0) ackb0_cnt <= ackb0_cnt + 1;
        if (ack_b1) ackb1_cnt <= ackb1_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_v0(output bit f);
        f = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid0) begin f = 1'b1; break; end
        end
    endtask

    task automatic wait_v1(output bit f);
        f = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid1) begin f = 1'b1; break; end
        end
    endtask

    task automatic wait_v2(output bit f);
        f = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid2) begin f = 1'b1; break; end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_a0 = 1'b0; req_b0 = 1'b0; data_a0 = 8'h00; data_b0 = 8'h00; out_ready0 = 1'b0;
        req_a1 = 1'b0; req_b1 = 1'b0; data_a1 = 8'h00; data_b1 = 8'h00; out_ready1 = 1'b0;
        req_a2 = 1'b0; req_b2 = 1'b0; data_a2 = 8'h00; data_b2 = 8'h00; out_ready2 = 1'b0;

        // Reset then idle
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_valid0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_sel", 32'(sel0), 32'd0);
        check("idle_data", 32'(out_data0), 32'h00);
        check("idle_valid", 32'(out_valid0), 32'd0);
        check("idle_ack_a", 32'(ack_a0), 32'd0);
        check("idle_ack_b", 32'(ack_b0), 32'd0);
        check("idle_busy", 32'(busy0), 32'd0);
        check("idle_cnt_a", 32'(cnt_a0), 32'd0);
        check("idle_cnt_b", 32'(cnt_b0), 32'd0);
        check("idle_busy1", 32'(busy1), 32'd0);
        check("idle_busy2", 32'(busy2), 32'd0);

        // Single A transfer
        req_a0 = 1'b1; data_a0 = 8'h3C; out_ready0 = 1'b1;
        @(negedge clk);
        check("a_load_sel", 32'(sel0), 32'd0);
        check("a_load_busy", 32'(busy0), 32'd1);
        check("a_load_valid", 32'(out_valid0), 32'd0);
        @(negedge clk);
        check("a_send_valid", 32'(out_valid0), 32'd1);
        check("a_send_data", 32'(out_data0), 32'h3C);
        check("a_send_ack_a", 32'(ack_a0), 32'd1);
        check("a_send_ack_b", 32'(ack_b0), 32'd0);
        req_a0 = 1'b0;
        @(negedge clk);
        check("a_done_valid", 32'(out_valid0), 32'd0);
        check("a_done_ack_a", 32'(ack_a0), 32'd0);
        check("a_done_cnt_a", 32'(cnt_a0), 32'd1);
        check("a_done_cnt_b", 32'(cnt_b0), 32'd0);
        check("a_done_busy", 32'(busy0), 32'd0);

        // Reset asserted while a byte waits in SEND
        req_a0 = 1'b1; data_a0 = 8'h5A; out_ready0 = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_pre_valid", 32'(out_valid0), 32'd1);
        rst_n = 1'b0; req_a0 = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid0), 32'd0);
        check("mid_rst_cnt_a", 32'(cnt_a0), 32'd0);
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_ack_a", 32'(ack_a0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin contention, A first after reset
        req_a0 = 1'b1; req_b0 = 1'b1; data_a0 = 8'h11; data_b0 = 8'h22; out_ready0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_v0(found);
            check("rr_found", 32'(found), 32'd1);
            check("rr_data", 32'(out_data0), 32'(rr_exp[k]));
            check("rr_sel", 32'(sel0), 32'(k % 2));
            check("rr_ack_a", 32'(ack_a0), 32'((k + 1) % 2));
        end
        req_a0 = 1'b0; req_b0 = 1'b0;
        @(negedge clk);
        check("rr_cnt_a", 32'(cnt_a0), 32'd2);
        check("rr_cnt_b", 32'(cnt_b0), 32'd2);
        check("rr_busy", 32'(busy0), 32'd0);

        // Backpressure on B
        hs_base = hs0_cnt; ackb_base = ackb0_cnt;
        req_b0 = 1'b1; data_b0 = 8'hA5; out_ready0 = 1'b0;
        @(negedge clk);
        check("bp_sel", 32'(sel0), 32'd1);
        @(negedge clk);
        check("bp_ack_b", 32'(ack_b0), 32'd1);
        req_b0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_hold_valid", 32'(out_valid0), 32'd1);
            check("bp_hold_data", 32'(out_data0), 32'hA5);
        end
        out_ready0 = 1'b1;
        @(negedge clk);
        check("bp_done_valid", 32'(out_valid0), 32'd0);
        check("bp_cnt_b", 32'(cnt_b0), 32'd3);
        check("bp_handshakes", 32'(hs0_cnt - hs_base), 32'd1);
        check("bp_ack_b_pulses", 32'(ackb0_cnt - ackb_base), 32'd1);

        // Fixed priority (dut1)
        ackb_base = ackb1_cnt;
        req_a1 = 1'b1; req_b1 = 1'b1; data_a1 = 8'h11; data_b1 = 8'h22; out_ready1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_v1(found);
            check("fp_found", 32'(found), 32'd1);
            check("fp_data", 32'(out_data1), 32'h11);
            check("fp_sel", 32'(sel1), 32'd0);
            check("fp_ack_a", 32'(ack_a1), 32'd1);
        end
        check("fp_no_ack_b", 32'(ackb1_cnt - ackb_base), 32'd0);
        req_a1 = 1'b0;
        wait_v1(found);
        check("fp_b_found", 32'(found), 32'd1);
        check("fp_b_data", 32'(out_data1), 32'h22);
        check("fp_b_sel", 32'(sel1), 32'd1);
        check("fp_b_ack_b", 32'(ack_b1), 32'd1);
        req_b1 = 1'b0;
        @(negedge clk);
        check("fp_cnt_a", 32'(cnt_a1), 32'd3);
        check("fp_cnt_b", 32'(cnt_b1), 32'd1);
        check("fp_busy", 32'(busy1), 32'd0);

        // Counter saturation with 2-bit counters (dut2)
        req_a2 = 1'b1; data_a2 = 8'h77; out_ready2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_v2(found);
            check("sat_found", 32'(found), 32'd1);
            check("sat_data", 32'(out_data2), 32'h77);
            check("sat_sel", 32'(sel2), 32'd0);
            check("sat_ack", {30'd0, ack_b2, ack_a2}, 32'd1);
            check("sat_cnt_mid", 32'(cnt_a2), 32'((k < 3) ? k : 3));
        end
        req_a2 = 1'b0;
        @(negedge clk);
        check("sat_cnt_a", 32'(cnt_a2), 32'd3);
        check("sat_cnt_b", 32'(cnt_b2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
